// File: rtl/lcd1602_bus_engine_if.sv
// Request/response handshake between the Z80 port logic and the LCD bus engine.
// The engine is the slave side; the CPU-facing glue is the master.
interface lcd1602_bus_engine_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic       req_rw;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;

   modport master (output req_valid, req_rs, req_rw, req_data,
                   input  req_ready, rsp_valid, rsp_data);
   modport slave  (input  req_valid, req_rs, req_rw, req_data,
                   output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/lcd1602_bus_engine.sv
// Timed HD44780 8-bit bus master: SETUP/EHI/HOLD strobe sequencing, bus reads and
// optional busy-flag polling after every write. All outputs are registered.
module lcd1602_bus_engine #(
   parameter int SETUP_CYC  = 2,
   parameter int EHIGH_CYC  = 5,
   parameter int HOLD_CYC   = 2,
   parameter int RECOV_CYC  = 4,
   parameter bit AUTO_BUSY  = 1'b1,
   parameter int POLL_LIMIT = 4096
) (
   input  logic                 in_clock,
   input  logic                 rst,
   lcd1602_bus_engine_if.slave  bus,
   output logic                 poll_err,
   output logic                 lcd_e,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic [7:0]           lcd_d_out,
   output logic                 lcd_d_oe,
   input  logic [7:0]           lcd_d_in
);
   localparam int MAX_AB  = (SETUP_CYC > EHIGH_CYC) ? SETUP_CYC : EHIGH_CYC;
   localparam int MAX_CD  = (HOLD_CYC > RECOV_CYC) ? HOLD_CYC : RECOV_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int PW      = $clog2(MAX_CYC + 1);
   localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] EHIGH_LD = PW'(EHIGH_CYC - 1);
   localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);
   localparam logic [PW-1:0] RECOV_LD = PW'(RECOV_CYC - 1);
   localparam logic [15:0]   LIMIT    = 16'(POLL_LIMIT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EHI   = 3'd2,
      HOLD  = 3'd3,
      RESP  = 3'd4,
      RECOV = 3'd5
   } state_t;

   state_t        state_r, state_s;
   logic [PW-1:0] phase_r, phase_s;
   logic          rs_r, rs_s, rw_r, rw_s;
   logic          poll_r, poll_s, again_r, again_s;
   logic [7:0]    d_r, d_s, samp_r, samp_s;
   logic [15:0]   cnt_r, cnt_s;
   logic          err_s, last_s, drive_s;

   // Next-state, phase counter and transaction bookkeeping.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      rs_s    = rs_r;
      rw_s    = rw_r;
      d_s     = d_r;
      poll_s  = poll_r;
      again_s = again_r;
      samp_s  = samp_r;
      cnt_s   = cnt_r;
      err_s   = poll_err;
      last_s  = (phase_r == PW'(0));
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               state_s = SETUP;
               phase_s = SETUP_LD;
               rs_s    = bus.req_rs;
               rw_s    = bus.req_rw;
               d_s     = bus.req_data;
               poll_s  = 1'b0;
               again_s = 1'b0;
               cnt_s   = 16'd0;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            if (last_s) begin
               state_s = EHI;
               phase_s = EHIGH_LD;
            end else begin
               phase_s = phase_r - PW'(1);
            end
         end
         EHI: begin
            if (last_s) begin
               state_s = HOLD;
               phase_s = HOLD_LD;
               samp_s  = rw_r ? lcd_d_in : samp_r;
            end else begin
               phase_s = phase_r - PW'(1);
            end
         end
         HOLD: begin
            if (!last_s) begin
               phase_s = phase_r - PW'(1);
            end else if (poll_r) begin
               state_s = RECOV;
               phase_s = RECOV_LD;
               // Out of poll budget with the panel still busy: give up, flag it.
               if (samp_r[7] && (cnt_r >= LIMIT)) begin
                  again_s = 1'b0;
                  err_s   = 1'b1;
               end else begin
                  again_s = samp_r[7];
               end
            end else if (rw_r) begin
               state_s = RESP;
            end else begin
               state_s = RECOV;
               phase_s = RECOV_LD;
               again_s = AUTO_BUSY;
            end
         end
         RESP: begin
            state_s = RECOV;
            phase_s = RECOV_LD;
         end
         RECOV: begin
            if (!last_s) begin
               phase_s = phase_r - PW'(1);
            end else if (again_r) begin
               state_s = SETUP;
               phase_s = SETUP_LD;
               poll_s  = 1'b1;
               rs_s    = 1'b0;
               rw_s    = 1'b1;
               again_s = 1'b0;
               cnt_s   = cnt_r + 16'd1;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      drive_s = (state_s == SETUP) || (state_s == EHI) || (state_s == HOLD);
   end

   // State register and registered bus/handshake outputs decoded from the next state.
   always_ff @(posedge in_clock) begin
      if (rst) begin
         state_r       <= IDLE;
         phase_r       <= PW'(0);
         rs_r          <= 1'b0;
         rw_r          <= 1'b1;
         d_r           <= 8'h00;
         poll_r        <= 1'b0;
         again_r       <= 1'b0;
         samp_r        <= 8'h00;
         cnt_r         <= 16'd0;
         poll_err      <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= 8'h00;
         lcd_e         <= 1'b0;
         lcd_rs        <= 1'b0;
         lcd_rw        <= 1'b1;
         lcd_d_out     <= 8'h00;
         lcd_d_oe      <= 1'b0;
      end else begin
         state_r       <= state_s;
         phase_r       <= phase_s;
         rs_r          <= rs_s;
         rw_r          <= rw_s;
         d_r           <= d_s;
         poll_r        <= poll_s;
         again_r       <= again_s;
         samp_r        <= samp_s;
         cnt_r         <= cnt_s;
         poll_err      <= err_s;
         bus.req_ready <= (state_s == IDLE);
         bus.rsp_valid <= (state_s == RESP);
         bus.rsp_data  <= (state_s == RESP) ? samp_r : bus.rsp_data;
         lcd_e         <= (state_s == EHI);
         lcd_rs        <= drive_s & rs_s;
         lcd_rw        <= ~drive_s | rw_s;
         lcd_d_oe      <= drive_s & ~rw_s;
         lcd_d_out     <= (drive_s & ~rw_s) ? d_s : 8'h00;
      end
   end
endmodule
